// File: rtl/index_gather.sv
// Replays one captured data frame in the order given by a sorted index list,
// one element per beat, and flags index lists that are not a permutation.
module index_gather #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_INPUTS    = 8,
  parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0]  data_in,
  input  logic [N_INPUTS*INDEX_WIDTH-1:0] idx_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [INDEX_WIDTH-1:0]          out_index,
  output logic [INDEX_WIDTH-1:0]          out_pos,
  output logic                            out_last,
  output logic                            perm_err,
  output logic                            dbg_state
);

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // valid and ready are both high; valid never depends on ready.
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_POS = INDEX_WIDTH'(N_INPUTS - 1);
  localparam logic [INDEX_WIDTH:0]   N_EXT    = (INDEX_WIDTH + 1)'(N_INPUTS);
  localparam int                     SEEN_W   = 1 << INDEX_WIDTH;

  state_t                 state, state_nxt;
  logic                   armed;
  logic [DATA_WIDTH-1:0]  data_q [N_INPUTS];
  logic [INDEX_WIDTH-1:0] idx_q  [N_INPUTS];
  logic [INDEX_WIDTH-1:0] pos;
  logic                   err_q, err_nxt;
  logic [SEEN_W-1:0]      seen;
  logic [INDEX_WIDTH-1:0] cur;
  logic                   capture, beat_done, at_last;

  assign capture   = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;
  assign at_last   = (pos == LAST_POS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = STREAM;
      STREAM:  if (beat_done && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = armed && (state == IDLE);
    out_valid = (state == STREAM);
    out_pos   = pos;
    out_index = idx_q[pos];
    out_data  = '0;
    if ({1'b0, out_index} < N_EXT) out_data = data_q[out_index];
    out_last  = out_valid && at_last;
    perm_err  = err_q;
    dbg_state = state;
  end

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  // Permutation check: any out-of-range index or repeated index is an error.
  always_comb begin
    seen    = '0;
    err_nxt = 1'b0;
    cur     = '0;
    for (int p = 0; p < N_INPUTS; p++) begin
      cur = idx_in[p*INDEX_WIDTH +: INDEX_WIDTH];
      if ({1'b0, cur} >= N_EXT) err_nxt = 1'b1;
      else if (seen[cur])       err_nxt = 1'b1;
      else                      seen[cur] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        data_q[k] <= '0;
        idx_q[k]  <= '0;
      end
      err_q <= 1'b0;
    end else if (capture) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        data_q[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
        idx_q[k]  <= idx_in[k*INDEX_WIDTH +: INDEX_WIDTH];
      end
      err_q <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       pos <= '0;
    else if (capture)              pos <= '0;
    else if (beat_done && !at_last) pos <= pos + 1'b1;
  end

endmodule

// File: tb/tb_index_gather.sv
// Directed bench for index_gather: sort replay, backpressure, permutation
// errors, frames offered mid-stream, reset mid-frame and tied data.
`timescale 1ns/100ps
module tb_index_gather;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] data_in = '0;
  logic [23:0]  idx_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [2:0]   out_index;
  logic [2:0]   out_pos;
  logic         out_last;
  logic         perm_err;
  logic         dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs = 0;
  int last_cyc = 0;
  int cap_cyc = 0;
  int hs_start = 0;

  index_gather dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .idx_in(idx_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_pos(out_pos), .out_last(out_last), .perm_err(perm_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      hs <= hs + 1;
      if (out_last) last_cyc <= cyc + 1;
    end
  end

  function automatic logic [255:0] d8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [23:0] i8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic send(input logic [255:0] d, input logic [23:0] ix);
    in_valid = 1'b1;
    data_in  = d;
    idx_in   = ix;
    chk("in_ready_before_capture", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cap_cyc  = cyc;
    hs_start = hs;
  endtask

  task automatic beat(input int p, input logic [255:0] expd, input logic [23:0] expi,
                      input logic experr, input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_pos"},   64'(out_pos),   64'(p));
    chk({tag, "_index"}, 64'(out_index), 64'(expi[p*3 +: 3]));
    chk({tag, "_data"},  64'(out_data),  64'(expd[p*32 +: 32]));
    chk({tag, "_last"},  64'(out_last),  64'(p == 7));
    chk({tag, "_err"},   64'(perm_err),  64'(experr));
  endtask

  task automatic stream(input logic [255:0] expd, input logic [23:0] expi, input logic experr,
                        input bit bp, input bit offer, input int nb);
    for (int p = 0; p < nb; p++) begin
      if (offer && p >= 2 && p <= 5) begin
        in_valid = 1'b1;
        data_in  = d8(99, 98, 97, 96, 95, 94, 93, 92);
        idx_in   = i8(0, 1, 2, 3, 4, 5, 6, 7);
      end else begin
        in_valid = 1'b0;
      end
      if (bp) begin
        out_ready = 1'b0;
        beat(p, expd, expi, experr, "stall");
        @(posedge clk);
        @(negedge clk);
        beat(p, expd, expi, experr, "held");
      end
      out_ready = 1'b1;
      beat(p, expd, expi, experr, "beat");
      if (offer) chk("in_ready_streaming", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (nb == 8) begin
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_ready", 64'(in_ready),  64'd1);
      chk("idle_state", 64'(dbg_state), 64'd0);
    end
  endtask

  initial begin
    logic [255:0] dk;
    logic [255:0] perm_d;
    logic [23:0]  perm_i;
    dk     = d8(0, 10, 20, 30, 40, 50, 60, 70);
    perm_d = d8(30, 30, 0, 10, 20, 40, 50, 60);
    perm_i = i8(3, 3, 0, 1, 2, 4, 5, 6);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready),  64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_pos",   64'(out_pos),   64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_err",   64'(perm_err),  64'd0);
    rst = 1'b0;
    #1;
    chk("release_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("release_ready_high", 64'(in_ready), 64'd1);

    // Basic reverse sort with continuous out_ready
    out_ready = 1'b1;
    send(dk, i8(7, 6, 5, 4, 3, 2, 1, 0));
    stream(d8(70, 60, 50, 40, 30, 20, 10, 0), i8(7, 6, 5, 4, 3, 2, 1, 0), 1'b0, 1'b0, 1'b0, 8);
    chk("basic_hs_count", 64'(hs - hs_start), 64'd8);
    chk("basic_cycles",   64'(last_cyc - cap_cyc), 64'd8);

    // Same frame under alternating backpressure
    send(dk, i8(7, 6, 5, 4, 3, 2, 1, 0));
    stream(d8(70, 60, 50, 40, 30, 20, 10, 0), i8(7, 6, 5, 4, 3, 2, 1, 0), 1'b0, 1'b1, 1'b0, 8);
    chk("bp_hs_count", 64'(hs - hs_start), 64'd8);
    chk("bp_cycles",   64'(last_cyc - cap_cyc), 64'd16);

    // Duplicate index flags perm_err; duplicated element emitted twice
    send(dk, perm_i);
    stream(perm_d, perm_i, 1'b1, 1'b0, 1'b0, 8);

    // Identity frame clears perm_err; a frame offered mid-stream is ignored
    send(dk, i8(0, 1, 2, 3, 4, 5, 6, 7));
    stream(dk, i8(0, 1, 2, 3, 4, 5, 6, 7), 1'b0, 1'b0, 1'b1, 8);

    // The offered frame goes in only now
    send(d8(99, 98, 97, 96, 95, 94, 93, 92), i8(0, 1, 2, 3, 4, 5, 6, 7));
    stream(d8(99, 98, 97, 96, 95, 94, 93, 92), i8(0, 1, 2, 3, 4, 5, 6, 7), 1'b0, 1'b0, 1'b0, 8);

    // Tied data values
    send(d8(5, 5, 5, 5, 5, 5, 5, 5), i8(0, 2, 4, 6, 1, 3, 5, 7));
    stream(d8(5, 5, 5, 5, 5, 5, 5, 5), i8(0, 2, 4, 6, 1, 3, 5, 7), 1'b0, 1'b0, 1'b0, 8);

    // Asynchronous reset at out_pos 4 of an erroneous frame
    send(dk, perm_i);
    stream(perm_d, perm_i, 1'b1, 1'b0, 1'b0, 4);
    chk("mid_pos_before_rst", 64'(out_pos), 64'd4);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_index", 64'(out_index), 64'd0);
    chk("mid_rst_pos",   64'(out_pos),   64'd0);
    chk("mid_rst_last",  64'(out_last),  64'd0);
    chk("mid_rst_err",   64'(perm_err),  64'd0);
    #1 rst = 1'b0;
    #1;
    chk("mid_release_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("mid_release_ready_high", 64'(in_ready), 64'd1);
    chk("mid_release_valid", 64'(out_valid), 64'd0);
    send(dk, i8(7, 6, 5, 4, 3, 2, 1, 0));
    stream(d8(70, 60, 50, 40, 30, 20, 10, 0), i8(7, 6, 5, 4, 3, 2, 1, 0), 1'b0, 1'b0, 1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/index_gather.md
# index_gather

Consumes the sorted index vector produced by the index-tracking compare-and-swap sorter network and reads the original data frame back in sorted order, one element per beat, over a valid/ready stream. It sits downstream of the sorter. It holds one frame of original data plus its index permutation, then emits data, index and position per beat. It flags index vectors that are not a valid permutation.

## Interface
- DATA_WIDTH, 32, width of one data element
- N_INPUTS, 8, elements per frame (≥2)
- INDEX_WIDTH, $clog2(N_INPUTS), width of one index
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  frame offered
- in_ready  out  1  block can accept a frame
- data_in  in  N_INPUTS*DATA_WIDTH  original data, element k at [k*DATA_WIDTH +: DATA_WIDTH]
- idx_in  in  N_INPUTS*INDEX_WIDTH  sorted index list, position p at [p*INDEX_WIDTH +: INDEX_WIDTH]
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_WIDTH  data_in[idx_in[pos]] of captured frame
- out_index  out  INDEX_WIDTH  idx_in[pos] of captured frame
- out_pos  out  INDEX_WIDTH  sorted position of current beat, 0..N_INPUTS-1
- out_last  out  1  high on beat with out_pos == N_INPUTS-1
- perm_err  out  1  captured idx_in is not a permutation of 0..N_INPUTS-1

## Operation
- States: IDLE, STREAM.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
  - register data_in and idx_in;
  - evaluate perm_err on idx_in (any duplicate, or any index ≥ N_INPUTS) and register it;
  - pos←0, go to STREAM.
- STREAM: in_ready=0, out_valid=1, outputs driven from the frame registers and the pos counter. in_valid is ignored; the frame registers do not change.
- On out_valid&&out_ready in STREAM:
  - if pos==N_INPUTS-1: go to IDLE;
  - else: pos←pos+1.
- Out-of-range index (N_INPUTS not a power of 2): out_data=0 for that beat; the beat is still emitted.
- perm_err holds its value for the whole frame. It updates only on the next frame capture.
- Duplicates do not abort streaming. The duplicated element is emitted once per occurrence.

## Timing
- Reset (async assert): state=IDLE, pos=0, in_ready=0, out_valid=0, out_data=0, out_index=0, out_pos=0, out_last=0, perm_err=0.
- in_ready rises on the first clk edge after rst deasserts.
- Capture at edge E: out_valid=1 with pos 0 from E onward (1-cycle latency).
- Streaming rate is 1 beat/cycle under continuous out_ready.
- Stall: while out_valid && !out_ready, all out_* hold stable.
- Last handshake at edge L: out_valid=0 and in_ready=1 after L. The next capture is possible at L+1.
- Minimum frame period is N_INPUTS+1 cycles. There is no overlap between frames.
- rst mid-STREAM aborts the frame immediately. No partial beats follow. The next frame starts at pos 0.
- Output values when out_valid=0 are don't-care, except directly after reset, where they are 0.

## Test plan
- Basic sort, N_INPUTS=8, out_ready=1:
  - stimulus: data_in element k = 10*k; idx_in = 7,6,5,4,3,2,1,0 (position 0 first);
  - response: out_data 70,60,…,0 on 8 consecutive cycles; out_pos 0..7; out_last only with 0; perm_err=0; in_ready=1 on the cycle after.
- Backpressure, same frame:
  - stimulus: out_ready alternating 1,0 starting with 0;
  - response: each beat held stable during the stall; exactly 8 handshakes; sequence unchanged; 16 cycles from first out_valid to last handshake.
- Permutation error:
  - stimulus: idx_in = 3,3,0,1,2,4,5,6;
  - response: perm_err=1 for the whole frame; out_data = 30,30,0,10,20,40,50,60;
  - follow-up: next frame with identity idx_in 0..7 clears perm_err at capture.
- Frame offered during STREAM:
  - stimulus: in_valid=1 with new data_in during beats 2–5;
  - response: in_ready=0; the current frame completes unchanged; the new frame is captured only after out_last completes.
- Reset mid-frame:
  - stimulus: assert rst asynchronously between edges at out_pos=4;
  - response: out_valid, in_ready and all outputs go to 0 immediately; in_ready=1 one edge after release; a new frame streams from out_pos=0.
- Tie values:
  - stimulus: data all 5, idx_in = 0,2,4,6,1,3,5,7;
  - response: out_index follows 0,2,4,6,1,3,5,7; out_data=5 on every beat; perm_err=0.
